// File: rtl/uart_arb_if.sv
// Signal bundle between uart_arb, its two TX requesters, the RX consumer and the uart.
interface uart_arb_if;
    logic [31:0] clkdiv;
    logic        req0_valid;
    logic [7:0]  req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [7:0]  req1_data;
    logic        req1_ready;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        rx_ovf;
    logic        rx_ovf_clr;
    logic        uart_we;
    logic        uart_re;
    logic [31:0] uart_so;
    logic [31:0] uart_si;
    logic        uart_wa;
    logic        tx_busy;

    // Arbiter view: it masters the uart strobes and answers the requesters.
    modport master (
        input  clkdiv, req0_valid, req0_data, req1_valid, req1_data,
               rx_ready, rx_ovf_clr, uart_si, uart_wa,
        output req0_ready, req1_ready, rx_valid, rx_data, rx_ovf,
               uart_we, uart_re, uart_so, tx_busy
    );

    // Environment view: requesters, RX consumer and uart.
    modport slave (
        output clkdiv, req0_valid, req0_data, req1_valid, req1_data,
               rx_ready, rx_ovf_clr, uart_si, uart_wa,
        input  req0_ready, req1_ready, rx_valid, rx_data, rx_ovf,
               uart_we, uart_re, uart_so, tx_busy
    );
endinterface

// File: rtl/uart_arb.sv
// Two-port round-robin TX arbiter in front of a register-mapped uart, plus an
// RX path that acknowledges received words and buffers bytes in a small FIFO.
//
// state   | meaning
// T_IDLE  | TX free; ready follows the round-robin grant
// T_LOAD  | uart_we held for clkdiv+1 cycles with uart_so stable
// T_DRAIN | waiting for the uart to drop uart_wa
// R_IDLE  | watching uart_si for a word with zero upper bits
// R_ACK   | uart_re held for clkdiv+1 cycles; uart_si not sampled
module uart_arb #(
    parameter int RX_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    uart_arb_if.master bus
);
    localparam int AW = $clog2(RX_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW:0] FULL_CNT = CW'(RX_DEPTH);

    typedef enum logic [1:0] {T_IDLE = 2'd0, T_LOAD = 2'd1, T_DRAIN = 2'd2} tx_state_t;
    typedef enum logic {R_IDLE = 1'b0, R_ACK = 1'b1} rx_state_t;

    tx_state_t   tx_state, tx_next;
    rx_state_t   rx_state, rx_next;
    logic [31:0] tx_cnt, rx_cnt;
    logic        last_grant;
    logic        grant0, grant1, tx_hs;
    logic [7:0]  so_byte;

    logic [7:0]  fifo_mem [RX_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic        fifo_empty, fifo_full;
    logic        rx_push, rx_pop, push_ok;
    logic        ovf_q;

    // Round-robin grant: a lone requester wins, a tie goes to the port not served last.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (tx_state == T_IDLE) begin
            if (bus.req0_valid && (!bus.req1_valid || last_grant))
                grant0 = 1'b1;
            else if (bus.req1_valid)
                grant1 = 1'b1;
        end
    end

    assign tx_hs = grant0 | grant1;

    // TX next-state: load after a handshake, drain once the hold counter expires.
    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            T_IDLE:  if (tx_hs) tx_next = T_LOAD;
            T_LOAD:  if (tx_cnt == 32'd0) tx_next = T_DRAIN;
            T_DRAIN: if (!bus.uart_wa) tx_next = T_IDLE;
            default: tx_next = T_IDLE;
        endcase
    end

    assign rx_push = (rx_state == R_IDLE) && (bus.uart_si[31:8] == 24'h0);

    // RX next-state: acknowledge each accepted word for one hold window.
    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            R_IDLE:  if (rx_push) rx_next = R_ACK;
            R_ACK:   if (rx_cnt == 32'd0) rx_next = R_IDLE;
            default: rx_next = R_IDLE;
        endcase
    end

    // State registers for both FSMs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= T_IDLE;
            rx_state <= R_IDLE;
        end else begin
            tx_state <= tx_next;
            rx_state <= rx_next;
        end
    end

    // TX datapath: capture the granted byte and load/count down the hold timer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_cnt     <= 32'd0;
            so_byte    <= 8'h00;
            last_grant <= 1'b1;
        end else if (tx_hs) begin
            tx_cnt     <= bus.clkdiv;
            so_byte    <= grant1 ? bus.req1_data : bus.req0_data;
            last_grant <= grant1;
        end else if (tx_state == T_LOAD && tx_cnt != 32'd0) begin
            tx_cnt <= tx_cnt - 32'd1;
        end
    end

    // RX hold timer: loaded on entry to R_ACK, counts down to terminal zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rx_cnt <= 32'd0;
        else if (rx_push)
            rx_cnt <= bus.clkdiv;
        else if (rx_state == R_ACK && rx_cnt != 32'd0)
            rx_cnt <= rx_cnt - 32'd1;
    end

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FULL_CNT);
    assign rx_pop     = !fifo_empty && bus.rx_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push_ok    = rx_push && (!fifo_full || rx_pop);

    // FIFO storage; contents are only observable when the FIFO is non-empty.
    always_ff @(posedge clk) begin
        if (push_ok)
            fifo_mem[wr_ptr] <= bus.uart_si[7:0];
    end

    // FIFO pointers, occupancy and sticky overflow (a new drop beats a clear).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + AW'(1);
            if (rx_pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, rx_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (rx_push && fifo_full && !rx_pop)
                ovf_q <= 1'b1;
            else if (bus.rx_ovf_clr)
                ovf_q <= 1'b0;
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.uart_we    = (tx_state == T_LOAD);
    assign bus.uart_re    = (rx_state == R_ACK);
    assign bus.uart_so    = {24'h0, so_byte};
    assign bus.tx_busy    = (tx_state != T_IDLE);
    assign bus.rx_valid   = !fifo_empty;
    assign bus.rx_data    = fifo_empty ? 8'h00 : fifo_mem[rd_ptr];
    assign bus.rx_ovf     = ovf_q;
endmodule
